// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI mode-0 responder.
package spi_pkg;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_t;

  localparam int SPI_BYTE_W    = 8;
  localparam int SPI_BIT_CNT_W = 3;

endpackage

// File: rtl/spi_responder_if.sv
// Byte-level valid/ready link between the SPI responder and its local user.
interface spi_responder_if;
  import spi_pkg::*;

  logic [SPI_BYTE_W-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [SPI_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  // master: the user logic feeding tx bytes and draining rx bytes
  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  // slave: the responder itself
  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, plus single-cycle
// rise/fall pulses derived from a registered copy of the synchronized value.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  assign sync_d[0] = d;

  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_chain
    assign sync_d[gi] = sync_q[gi-1];
  end

  assign prev_d = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise =  q & ~prev_q;
  assign fall = ~q &  prev_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 device end: oversamples the master's pins in the clk domain and
// exchanges bytes with local logic over a valid/ready interface.
module spi_responder
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0] FILL_BYTE   = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_cs,
  input  logic             spi_sclk,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  spi_responder_if.slave   byte_if,
  output logic             rx_overrun,
  output logic             tx_underrun,
  output logic             busy
);

  logic cs_s, cs_rise, cs_fall;
  logic sck_s, sck_rise, sck_fall;
  logic mosi_s;
  logic [1:0] unused_mosi_edges;
  logic unused_sck_level;
  logic unused_cs_level;

  // cs idles high so reset must not fabricate a falling edge
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d(spi_cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .d(spi_sclk), .q(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s),
    .rise(unused_mosi_edges[0]), .fall(unused_mosi_edges[1])
  );

  assign unused_sck_level = sck_s;
  assign unused_cs_level  = cs_s;

  spi_state_t state_q, state_d;

  logic [SPI_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SPI_BYTE_W-1:0]    rx_shift_q, rx_shift_d;
  logic [SPI_BYTE_W-1:0]    tx_shift_q, tx_shift_d;
  logic [SPI_BYTE_W-1:0]    hold_q, hold_d;
  logic                     hold_full_q, hold_full_d;
  logic [SPI_BYTE_W-1:0]    rx_data_q, rx_data_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     rx_overrun_q, rx_overrun_d;
  logic                     tx_underrun_q, tx_underrun_d;
  logic                     miso_q, miso_d;
  logic                     miso_oe_q, miso_oe_d;
  logic                     load_tx;
  logic [SPI_BYTE_W-1:0]    rx_byte;

  assign rx_byte = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SPI_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SPI_IDLE:   if (cs_fall) state_d = SPI_ACTIVE;
      SPI_ACTIVE: if (cs_rise) state_d = SPI_IDLE;
      default:    state_d = SPI_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = rx_overrun_q;
    tx_underrun_d = tx_underrun_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    load_tx       = 1'b0;

    // holding register is only written while empty, so it never collides with a load
    if (byte_if.tx_valid && !hold_full_q) begin
      hold_d      = byte_if.tx_data;
      hold_full_d = 1'b1;
    end

    if (rx_valid_q && byte_if.rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      SPI_IDLE: begin
        if (cs_fall) begin
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          miso_oe_d  = 1'b1;
          load_tx    = 1'b1;
        end
      end
      SPI_ACTIVE: begin
        if (cs_rise) begin
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          miso_oe_d  = 1'b0;
          miso_d     = 1'b1;
        end else if (sck_rise) begin
          rx_shift_d = rx_byte;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == SPI_BIT_CNT_W'(SPI_BYTE_W - 1)) begin
            if (!rx_valid_q || byte_if.rx_ready) begin
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
            end else begin
              rx_overrun_d = 1'b1;
            end
          end
        end else if (sck_fall) begin
          if (bit_cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
            miso_d     = tx_shift_q[SPI_BYTE_W-2];
          end else begin
            load_tx = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (load_tx) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d    = FILL_BYTE;
        tx_underrun_d = 1'b1;
      end
      miso_d = tx_shift_d[SPI_BYTE_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      miso_q        <= 1'b1;
      miso_oe_q     <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
    end
  end

  assign spi_miso         = miso_q;
  assign spi_miso_oe      = miso_oe_q;
  assign byte_if.tx_ready = ~hold_full_q;
  assign byte_if.rx_data  = rx_data_q;
  assign byte_if.rx_valid = rx_valid_q;
  assign rx_overrun       = rx_overrun_q;
  assign tx_underrun      = tx_underrun_q;
  assign busy             = (state_q == SPI_ACTIVE);

endmodule
